// File: rtl/sha3_round_scheduler.sv
// -----------------------------------------------------------------------------
// sha3_round_scheduler
// Control-only sequencer for one fixed-depth pipelined Keccak round datapath
// that is time-shared by up to PIPE_DEPTH independent states. A shadow shift
// register mirrors the datapath pipeline. Each cycle the block decides whether
// the datapath input takes the recirculated round output or a fresh state. It
// also supplies the round index used by iota and flags finished states.
//
// Ports:
//   clk            clock, all state on rising edge
//   rst            asynchronous active-low reset
//   in_valid       fresh state present on datapath input
//   in_tag         caller tag of the fresh state
//   in_ready       fresh state accepted this cycle when in_valid is high
//   round_sample   datapath sample strobe
//   round_recirc   input mux select: 1 = recirculated output, 0 = fresh input
//   round_index    round number of the state entering the datapath
//   round_good     datapath output-good indication (cross-checked)
//   out_valid      one-cycle pulse: datapath output is a finished state
//   out_tag        tag of the finished state (0 when out_valid is low)
//   in_flight      registered count of occupied shadow slots
//   protocol_error sticky: round_good disagreed with the shadow pipeline
// -----------------------------------------------------------------------------
module sha3_round_scheduler #(
  parameter int PIPE_DEPTH = 4,
  parameter int ROUNDS     = 24,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 in_ready,
  output logic                 round_sample,
  output logic                 round_recirc,
  output logic [4:0]           round_index,
  input  logic                 round_good,
  output logic                 out_valid,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic [3:0]           in_flight,
  output logic                 protocol_error
);

  generate
    if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_depth
      $error("sha3_round_scheduler: PIPE_DEPTH must be in 1..8");
    end
    if (ROUNDS < 1 || ROUNDS > 24) begin : g_bad_rounds
      $error("sha3_round_scheduler: ROUNDS must be in 1..24");
    end
  endgenerate

  localparam int         LAST        = PIPE_DEPTH - 1;
  localparam logic [4:0] FINAL_ROUND = 5'(ROUNDS - 1);

  // Shadow pipeline: entry 0 is loaded from the datapath input side, entry
  // LAST is the state currently presented at the datapath output.
  logic                 r_valid [PIPE_DEPTH];
  logic [TAG_WIDTH-1:0] r_tag   [PIPE_DEPTH];
  logic [4:0]           r_round [PIPE_DEPTH];
  logic [3:0]           r_in_flight;
  logic                 r_protocol_error;

  logic                 w_exit_valid;
  logic                 w_recirc;
  logic                 w_finish;
  logic [4:0]           w_round_inc;
  logic [TAG_WIDTH-1:0] w_head_tag;
  logic [4:0]           w_head_round;
  logic [3:0]           w_in_flight_next;

  assign w_exit_valid = r_valid[LAST];
  // Rounds never exceed FINAL_ROUND, so "not final" is the same as "below
  // final" and avoids a constant compare when ROUNDS is 1.
  assign w_recirc     = w_exit_valid && (r_round[LAST] != FINAL_ROUND);
  assign w_finish     = w_exit_valid && (r_round[LAST] == FINAL_ROUND);
  assign w_round_inc  = r_round[LAST] + 5'd1;

  always_comb begin
    in_ready     = !w_recirc;
    round_sample = w_recirc || in_valid;
    round_recirc = w_recirc;
    round_index  = 5'd0;
    out_valid    = w_finish;
    out_tag      = '0;
    w_head_tag   = in_tag;
    w_head_round = 5'd0;
    if (w_recirc) begin
      round_index  = w_round_inc;
      w_head_tag   = r_tag[LAST];
      w_head_round = w_round_inc;
    end
    if (w_finish) begin
      out_tag = r_tag[LAST];
    end
  end

  // Occupancy changes by -1 when a state leaves the exit slot and +1 when
  // something is sampled; a finish plus an injection cancels out.
  assign w_in_flight_next = r_in_flight - {3'b000, w_exit_valid} + {3'b000, round_sample};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_round[i] <= 5'd0;
      end
      r_in_flight      <= 4'd0;
      r_protocol_error <= 1'b0;
    end else begin
      r_valid[0] <= round_sample;
      r_tag[0]   <= w_head_tag;
      r_round[0] <= w_head_round;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
        r_round[i] <= r_round[i-1];
      end
      r_in_flight <= w_in_flight_next;
      // Scheduling follows the shadow state only; round_good is checked.
      if (round_good != w_exit_valid) begin
        r_protocol_error <= 1'b1;
      end
    end
  end

  assign in_flight      = r_in_flight;
  assign protocol_error = r_protocol_error;

endmodule

// File: doc/sha3_round_scheduler.md
Name: sha3_round_scheduler

Overview:
- Control-only sequencer that time-shares one pipelined SHA-3 round datapath (theta→rho→chi→iota, fixed depth) across up to PIPE_DEPTH independent Keccak-f states in flight.
- Decides each cycle whether the round input takes a fresh state or the recirculated round output.
- Supplies the runtime round index for iota's constant selection.
- Tags each state and announces completion after ROUNDS passes; the 5x5 matrices and the inject/recirculate mux live outside this block.

Parameters:
- PIPE_DEPTH, 4: cycles from round-input sample to round-output good; 1..8.
- ROUNDS, 24: round passes per permutation; 1..24.
- TAG_WIDTH, 4: width of the caller-supplied state tag.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  fresh state present on datapath input.
- in_tag  input  TAG_WIDTH  tag of fresh state.
- in_ready  output  1  fresh state accepted this cycle when in_valid high.
- round_sample  output  1  drives round datapath sample.
- round_recirc  output  1  mux select: 1 = recirculated round output, 0 = fresh input.
- round_index  output  5  round number of the state entering the datapath.
- round_good  input  1  round datapath good.
- out_valid  output  1  one-cycle pulse; round datapath output is a finished state.
- out_tag  output  TAG_WIDTH  tag of finished state, valid with out_valid.
- in_flight  output  4  number of occupied shadow slots, 0..PIPE_DEPTH.
- protocol_error  output  1  sticky; round_good disagreed with the shadow pipeline.

Behaviour:
- Shadow pipeline: PIPE_DEPTH-entry shift register; each entry is {valid, tag, round[4:0]} and advances every cycle. The exit entry is the one whose state appears at the datapath output this cycle.
- Exit entry valid with round < ROUNDS-1 (recirculate):
  - round_sample=1, round_recirc=1, round_index = exit round+1, same cycle (combinational).
  - Head entry loads {1, exit tag, exit round+1}.
  - in_ready=0.
- Exit entry valid with round == ROUNDS-1 (finish):
  - out_valid=1 and out_tag = exit tag, combinational.
  - The slot is free, so in_ready=1 and the injection rule applies the same cycle.
- Slot free (exit invalid, or exit finished):
  - in_ready=1.
  - If in_valid: round_sample=1, round_recirc=0, round_index=0, head loads {1, in_tag, 0}.
  - Otherwise round_sample=0 and head loads invalid.
- Recirculation always beats injection; there is no stall path (the datapath cannot stall). out_valid has no backpressure; the consumer must capture the state on the pulse.
- When round_sample=0: round_recirc=0 and round_index=0.
- Latency: a state injected at cycle t finishes (out_valid) at cycle t+ROUNDS*PIPE_DEPTH; 96 cycles at the defaults.
- Throughput: PIPE_DEPTH states per ROUNDS*PIPE_DEPTH cycles.
- ROUNDS=1: injected state finishes at t+PIPE_DEPTH and never recirculates.
- in_flight: registered; it is the popcount of valid shadow entries after the clock edge. A finish combined with an injection in the same cycle leaves the count unchanged.
- protocol_error:
  - Set on any cycle where round_good != exit entry valid.
  - Stays set until reset.
  - Scheduling continues from the shadow state, ignoring round_good.
- Reset (rst low, asynchronous, including mid-operation):
  - All shadow entries invalid; in_flight=0; protocol_error=0.
  - Hence round_sample=0, round_recirc=0, round_index=0, out_valid=0, out_tag=0, in_ready=1.
  - In-flight states are dropped with no out_valid. The datapath must be reset on the same rst so round_good stays consistent.
- Elaboration error if PIPE_DEPTH is outside 1..8 or ROUNDS is outside 1..24.

Test Plan:
- Single state: in_valid pulse at cycle 10, tag 0x3 → round_sample with round_recirc=0, index 0 at cycle 10. Recirculations at cycles 14, 18, …, 102 with indices 1..23. out_valid with tag 0x3 at cycle 106. in_flight returns to 0 at cycle 107.
- Full occupancy: in_valid held high with tags 0..7 from cycle 0 → tags 0..3 accepted at cycles 0..3. in_ready=0 for cycles 4..95. Tag 0 finishes at 96 and tag 4 is injected at 96 (same cycle). Tags 1..3 finish at 97..99 while tags 5..7 are injected. in_flight stays 4.
- Round index sweep: single state → round_index sequence observed on round_sample cycles equals 0,1,…,23 exactly once each. No sample at round 24.
- Reset mid-flight: 3 states in flight, rst low at cycle 50 for 2 cycles → all outputs at reset values immediately (asynchronously). No out_valid ever appears for those tags. A new state injected at cycle 60 finishes at cycle 156.
- Protocol fault: force round_good=1 at a cycle with exit invalid → protocol_error=1 from the next cycle and held. Scheduling of other states is unaffected. Cleared only by rst.
- ROUNDS=1, PIPE_DEPTH=1 build: back-to-back in_valid with tags 1,2,3 at cycles 0,1,2 → all accepted. out_valid with tags 1,2,3 at cycles 1,2,3. round_recirc stays 0 throughout.
